regfile_sb: RTL and testbench

- Parametrised successor to the team's 8x16 register file. Adds configurable width/depth, optional hardwired-zero entry 0 and optional write-to-read bypass.
- Adds a per-entry pending-write scoreboard (busy bits) for the pipelined datapath.
- Adds a sequential clear-sweep engine that zeroes the file one entry per cycle.
- Sits between the decode stage (reads, issue) and the writeback stage (writes).

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 43 ++++
 rtl/regfile_sb.sv | 128 ++++++++++++
 tb/tb_regfile_sb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and helpers for the scoreboarded register file.
// Holds the sweep FSM state type and the depth helper.
package rf_pkg;

   typedef enum logic [0:0] {
      RF_IDLE  = 1'b0,
      RF_SWEEP = 1'b1
   } rf_state_t;

   function automatic int rf_depth(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write busy bits, one per register file entry.
// Ports: i_set_en/i_set_idx mark pending, i_clr_en/i_clr_idx
// clear on writeback, i_sweep/i_sweep_idx clear during a sweep,
// o_busy is the full busy vector.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_set_en,
   input  logic [ADDR_W-1:0] i_set_idx,
   input  logic              i_clr_en,
   input  logic [ADDR_W-1:0] i_clr_idx,
   input  logic              i_sweep,
   input  logic [ADDR_W-1:0] i_sweep_idx,
   output logic [DEPTH-1:0]  o_busy
);

   logic [DEPTH-1:0] r_busy;

   // Set is applied after clear so an issue to the entry being
   // written in the same cycle leaves it pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else if (i_sweep) begin
         r_busy[i_sweep_idx] <= 1'b0;
      end else begin
         if (i_clr_en) begin
            r_busy[i_clr_idx] <= 1'b0;
         end
         if (i_set_en) begin
            r_busy[i_set_idx] <= 1'b1;
         end
      end
   end

   assign o_busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with busy scoreboard, optional
// zero entry, optional write bypass and a clear-sweep engine.
// Ports: src0/src1 -> data0/data1, busy0/busy1 (combinational);
// we/dst/data writeback; issue_we/issue_dst mark pending;
// clr starts a sweep, clr_busy high while sweeping.
module regfile_sb
   import rf_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] src0,
   input  logic [ADDR_W-1:0] src1,
   output logic [DATA_W-1:0] data0,
   output logic [DATA_W-1:0] data1,
   output logic              busy0,
   output logic              busy1,
   input  logic              we,
   input  logic [ADDR_W-1:0] dst,
   input  logic [DATA_W-1:0] data,
   input  logic              issue_we,
   input  logic [ADDR_W-1:0] issue_dst,
   input  logic              clr,
   output logic              clr_busy
);

   localparam int DEPTH = rf_depth(ADDR_W);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   localparam logic HAS_ZERO = (ZERO_REG != 0);
   localparam logic HAS_BYP  = (BYPASS != 0);

   rf_state_t         r_state;
   logic [ADDR_W-1:0] r_idx;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  w_busy;
   logic              w_idle;
   logic              w_sweep;
   logic              w_wr_en;
   logic              w_iss_en;

   assign w_idle  = (r_state == RF_IDLE);
   assign w_sweep = ~w_idle;

   // Entry 0 swallows writes and issues when hardwired to zero.
   assign w_wr_en  = we & w_idle
                   & ~(HAS_ZERO & (dst == '0));
   assign w_iss_en = issue_we & w_idle
                   & ~(HAS_ZERO & (issue_dst == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_state <= RF_IDLE;
         r_idx   <= '0;
      end else begin
         unique case (r_state)
            RF_IDLE: begin
               if (w_wr_en) begin
                  r_mem[dst] <= data;
               end
               if (clr) begin
                  r_state <= RF_SWEEP;
                  r_idx   <= '0;
               end
            end
            RF_SWEEP: begin
               r_mem[r_idx] <= '0;
               r_idx        <= r_idx + ADDR_W'(1);
               if (r_idx == LAST) begin
                  r_state <= RF_IDLE;
               end
            end
            default: r_state <= RF_IDLE;
         endcase
      end
   end

   rf_scoreboard #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .i_set_en    (w_iss_en),
      .i_set_idx   (issue_dst),
      .i_clr_en    (w_wr_en),
      .i_clr_idx   (dst),
      .i_sweep     (w_sweep),
      .i_sweep_idx (r_idx),
      .o_busy      (w_busy)
   );

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [ADDR_W-1:0] w_a;
      logic [DATA_W-1:0] w_d;
      logic              w_b;

      assign w_a = (p == 0) ? src0 : src1;

      // Forwarded data is never pending: a same-cycle issue to
      // this entry only shows as busy after the edge.
      always_comb begin
         w_d = r_mem[w_a];
         w_b = w_busy[w_a];
         if (HAS_BYP && w_idle && we && (dst == w_a)) begin
            w_d = data;
            w_b = 1'b0;
         end
         if (HAS_ZERO && (w_a == '0)) begin
            w_d = '0;
            w_b = 1'b0;
         end
      end
   end

   assign data0    = g_rd[0].w_d;
   assign busy0    = g_rd[0].w_b;
   assign data1    = g_rd[1].w_d;
   assign busy1    = g_rd[1].w_b;
   assign clr_busy = w_sweep;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: three instances
// (default, no bypass, zero entry) against a reference model.
module tb_regfile_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       we, iw, clr;
   logic [3:0] src0, src1, dst, idst;
   logic [7:0] data;

   logic [2:0][7:0] d0, d1;
   logic [2:0]      b0, b1, cb;

   regfile_sb #(.ZERO_REG(0), .BYPASS(1)) u_a (
      .clk(clk), .rst(rst), .src0(src0), .src1(src1),
      .data0(d0[0]), .data1(d1[0]),
      .busy0(b0[0]), .busy1(b1[0]),
      .we(we), .dst(dst), .data(data),
      .issue_we(iw), .issue_dst(idst),
      .clr(clr), .clr_busy(cb[0]));

   regfile_sb #(.ZERO_REG(0), .BYPASS(0)) u_b (
      .clk(clk), .rst(rst), .src0(src0), .src1(src1),
      .data0(d0[1]), .data1(d1[1]),
      .busy0(b0[1]), .busy1(b1[1]),
      .we(we), .dst(dst), .data(data),
      .issue_we(iw), .issue_dst(idst),
      .clr(clr), .clr_busy(cb[1]));

   regfile_sb #(.ZERO_REG(1), .BYPASS(1)) u_z (
      .clk(clk), .rst(rst), .src0(src0), .src1(src1),
      .data0(d0[2]), .data1(d1[2]),
      .busy0(b0[2]), .busy1(b1[2]),
      .we(we), .dst(dst), .data(data),
      .issue_we(iw), .issue_dst(idst),
      .clr(clr), .clr_busy(cb[2]));

   int total = 0;
   int bad   = 0;

   // model: index 0 = normal entry 0, 1 = hardwired-zero entry 0
   int m_mem  [2][16];
   bit m_busy [2][16];
   bit m_sw;
   int m_idx;

   int s_d0, s_b0, s_d1, s_b1, s_cb, s_d1nb, s_d0z, s_b0z;

   typedef struct {
      bit we; int dst; int data; bit iw; int idst;
      int s0; int s1;
      int ed0; int eb0; int ed1; int eb1;
   } vec_t;

   vec_t tbl [13];

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int z = 0; z < 2; z++)
         for (int i = 0; i < 16; i++) begin
            m_mem[z][i]  = 0;
            m_busy[z][i] = 0;
         end
      m_sw  = 0;
      m_idx = 0;
   endtask

   task automatic model_edge();
      if (!m_sw) begin
         for (int z = 0; z < 2; z++) begin
            if (we && !(z == 1 && dst == 0)) begin
               m_mem[z][dst]  = data;
               m_busy[z][dst] = 0;
            end
            if (iw && !(z == 1 && idst == 0))
               m_busy[z][idst] = 1;
         end
         if (clr) begin
            m_sw  = 1;
            m_idx = 0;
         end
      end else begin
         for (int z = 0; z < 2; z++) begin
            m_mem[z][m_idx]  = 0;
            m_busy[z][m_idx] = 0;
         end
         if (m_idx == 15) m_sw = 0;
         m_idx = (m_idx + 1) % 16;
      end
   endtask

   task automatic expect_rd(input int k, input int a,
                            output int ed, output int eb);
      int z;
      z  = (k == 2) ? 1 : 0;
      ed = m_mem[z][a];
      eb = int'(m_busy[z][a]);
      if (k != 1 && !m_sw && we && int'(dst) == a) begin
         ed = data;
         eb = 0;
      end
      if (z == 1 && a == 0) begin
         ed = 0;
         eb = 0;
      end
   endtask

   task automatic step(input bit i_we, input int i_dst,
                       input int i_data, input bit i_iw,
                       input int i_idst, input bit i_clr,
                       input int i_s0, input int i_s1);
      int ed, eb;
      we   = i_we;
      dst  = 4'(i_dst);
      data = 8'(i_data);
      iw   = i_iw;
      idst = 4'(i_idst);
      clr  = i_clr;
      src0 = 4'(i_s0);
      src1 = 4'(i_s1);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         expect_rd(k, i_s0, ed, eb);
         check($sformatf("d0[%0d] a=%0d", k, i_s0), d0[k], ed);
         check($sformatf("b0[%0d] a=%0d", k, i_s0), b0[k], eb);
         expect_rd(k, i_s1, ed, eb);
         check($sformatf("d1[%0d] a=%0d", k, i_s1), d1[k], ed);
         check($sformatf("b1[%0d] a=%0d", k, i_s1), b1[k], eb);
         check($sformatf("clr_busy[%0d]", k), cb[k], m_sw);
      end
      s_d0   = d0[0];
      s_b0   = b0[0];
      s_d1   = d1[0];
      s_b1   = b1[0];
      s_cb   = cb[0];
      s_d1nb = d1[1];
      s_d0z  = d0[2];
      s_b0z  = b0[2];
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Asserted between edges: outputs must clear at once.
   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s cb[%0d]", tag, k), cb[k], 0);
         check($sformatf("%s d0[%0d]", tag, k), d0[k], 0);
         check($sformatf("%s d1[%0d]", tag, k), d1[k], 0);
         check($sformatf("%s b0[%0d]", tag, k), b0[k], 0);
      end
      model_reset();
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   int cnt;

   initial begin
      rst = 1'b1;
      we = 0; iw = 0; clr = 0;
      dst = 0; idst = 0; data = 0; src0 = 0; src1 = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      // dirty the file, then reset mid-cycle
      step(1, 3, 'h99, 1, 3, 0, 3, 0);
      step(0, 0, 0, 0, 0, 0, 3, 3);
      async_reset("rst1");

      tbl[0]  = '{1, 3, 'hA5, 0, 0, 3, 0, 'hA5, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 3, 5, 'hA5, 0, 0, 0};
      tbl[2]  = '{1, 5, 'h3C, 0, 0, 3, 5, 'hA5, 0, 'h3C, 0};
      tbl[3]  = '{0, 0, 0, 1, 7, 7, 5, 0, 0, 'h3C, 0};
      tbl[4]  = '{0, 0, 0, 0, 0, 7, 5, 0, 1, 'h3C, 0};
      tbl[5]  = '{0, 0, 0, 0, 0, 7, 5, 0, 1, 'h3C, 0};
      tbl[6]  = '{0, 0, 0, 0, 0, 7, 5, 0, 1, 'h3C, 0};
      tbl[7]  = '{1, 7, 'h11, 0, 0, 7, 5, 'h11, 0, 'h3C, 0};
      tbl[8]  = '{0, 0, 0, 0, 0, 7, 5, 'h11, 0, 'h3C, 0};
      tbl[9]  = '{1, 2, 'h5A, 1, 2, 2, 3, 'h5A, 0, 'hA5, 0};
      tbl[10] = '{0, 0, 0, 0, 0, 2, 7, 'h5A, 1, 'h11, 0};
      tbl[11] = '{1, 0, 'hFF, 1, 0, 0, 2, 'hFF, 0, 'h5A, 1};
      tbl[12] = '{0, 0, 0, 0, 0, 0, 2, 'hFF, 1, 'h5A, 1};

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].we, tbl[i].dst, tbl[i].data, tbl[i].iw,
              tbl[i].idst, 0, tbl[i].s0, tbl[i].s1);
         check($sformatf("tbl%0d d0", i), s_d0, tbl[i].ed0);
         check($sformatf("tbl%0d b0", i), s_b0, tbl[i].eb0);
         check($sformatf("tbl%0d d1", i), s_d1, tbl[i].ed1);
         check($sformatf("tbl%0d b1", i), s_b1, tbl[i].eb1);
         if (i == 2) check("nobyp old", s_d1nb, 0);
         if (i == 3) check("nobyp new", s_d1nb, 'h3C);
         if (i >= 11) begin
            check($sformatf("zero d0 %0d", i), s_d0z, 0);
            check($sformatf("zero b0 %0d", i), s_b0z, 0);
         end
      end

      // full sweep
      for (int i = 0; i < 16; i++)
         step(1, i, 'h10 + i, 0, 0, 0, i, 0);
      step(0, 0, 0, 1, 9, 0, 9, 15);
      step(0, 0, 0, 0, 0, 1, 9, 15);
      cnt = 0;
      for (int n = 0; n < 40; n++) begin
         step(n == 2, 15, 'h77, n == 3, 15, n == 5,
              (n == 0) ? 0 : (n - 1) % 16, 15);
         if (n == 4) begin
            check("sweep c4 e3", s_d0, 0);
            check("sweep c4 e15", s_d1, 'h1F);
         end
         if (s_cb == 1) cnt++;
         else if (cnt > 0) break;
      end
      check("sweep length", cnt, 16);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, 0, 0, 0, i, 15 - i);
         check($sformatf("post sweep d%0d", i), s_d0, 0);
         check($sformatf("post sweep b%0d", i), s_b0, 0);
      end

      // reset in the middle of a sweep
      for (int i = 0; i < 16; i++)
         step(1, i, 'h20 + i, i == 12, 12, 0, i, 0);
      step(0, 0, 0, 0, 0, 1, 12, 15);
      for (int n = 0; n < 8; n++)
         step(0, 0, 0, 0, 0, 0, 12, 15);
      check("mid sweep busy", s_cb, 1);
      async_reset("rst2");
      step(0, 0, 0, 0, 0, 0, 12, 15);

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         step($urandom_range(1, 0) == 1,
              int'($urandom_range(15, 0)),
              int'($urandom_range(255, 0)),
              $urandom_range(3, 0) == 0,
              int'($urandom_range(15, 0)),
              $urandom_range(59, 0) == 0,
              int'($urandom_range(15, 0)),
              int'($urandom_range(15, 0)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
